// File: rtl/seq_alu_pkg.sv
// ============================================================================
// Module   : seq_alu_pkg
// Purpose  : Opcode and state encodings shared by the sequential ALU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_alu_pkg;

    typedef enum logic [3:0] {
        OP_AND = 4'd0,
        OP_OR  = 4'd1,
        OP_XOR = 4'd2,
        OP_NOT = 4'd3,
        OP_ADD = 4'd4,
        OP_SUB = 4'd5,
        OP_INC = 4'd6,
        OP_NEG = 4'd7,
        OP_SHL = 4'd8,
        OP_SHR = 4'd9,
        OP_SRA = 4'd10,
        OP_MUL = 4'd11
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    // Opcodes at or above this value are reserved.
    localparam logic [3:0] OP_RSVD_FIRST = 4'd12;

endpackage

`default_nettype wire

// File: rtl/alu_core_comb.sv
// ============================================================================
// Module   : alu_core_comb
// Purpose  : Combinational datapath for every single-cycle opcode and flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_core_comb
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [3:0]       op_i,
    output logic [WIDTH-1:0] result_o,
    output logic             z_o,
    output logic             n_o,
    output logic             c_o,
    output logic             v_o,
    output logic             err_o
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0]        w_add_x;
    logic [WIDTH-1:0]        w_add_y;
    logic                    w_add_cin;
    logic [WIDTH:0]          w_add_sum;
    logic                    w_add_v;
    logic [SHW-1:0]          w_amt;
    logic [WIDTH:0]          w_shl;
    logic [WIDTH:0]          w_shr;
    logic signed [WIDTH:0]   w_sra;
    logic [WIDTH-1:0]        w_res;

    // One shared adder serves ADD, SUB (a+~b+1), INC (b+0+1) and NEG (~a+0+1).
    always_comb begin
        w_add_x   = a_i;
        w_add_y   = b_i;
        w_add_cin = 1'b0;
        case (op_i)
            OP_SUB: begin
                w_add_y   = ~b_i;
                w_add_cin = 1'b1;
            end
            OP_INC: begin
                w_add_x   = b_i;
                w_add_y   = '0;
                w_add_cin = 1'b1;
            end
            OP_NEG: begin
                w_add_x   = ~a_i;
                w_add_y   = '0;
                w_add_cin = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_add_sum = {1'b0, w_add_x} + {1'b0, w_add_y} + {{WIDTH{1'b0}}, w_add_cin};
    assign w_add_v   = w_add_x[WIDTH-1] ^ w_add_y[WIDTH-1] ^ w_add_sum[WIDTH-1] ^ w_add_sum[WIDTH];

    // A spare bit beside each shift catches the last bit pushed out.
    assign w_amt = b_i[SHW-1:0];
    assign w_shl = {1'b0, a_i} << w_amt;
    assign w_shr = {a_i, 1'b0} >> w_amt;
    assign w_sra = $signed({a_i, 1'b0}) >>> w_amt;

    always_comb begin
        w_res = '0;
        c_o   = 1'b0;
        v_o   = 1'b0;
        err_o = 1'b0;
        case (op_i)
            OP_AND: w_res = a_i & b_i;
            OP_OR:  w_res = a_i | b_i;
            OP_XOR: w_res = a_i ^ b_i;
            OP_NOT: w_res = ~b_i;
            OP_ADD, OP_SUB: begin
                w_res = w_add_sum[WIDTH-1:0];
                c_o   = w_add_sum[WIDTH];
                v_o   = w_add_v;
            end
            OP_INC: begin
                w_res = w_add_sum[WIDTH-1:0];
                c_o   = w_add_sum[WIDTH];
                v_o   = (b_i == ~MSB_ONLY);
            end
            OP_NEG: begin
                w_res = w_add_sum[WIDTH-1:0];
                c_o   = w_add_sum[WIDTH];
                v_o   = (a_i == MSB_ONLY);
            end
            OP_SHL: begin
                w_res = w_shl[WIDTH-1:0];
                c_o   = w_shl[WIDTH];
            end
            OP_SHR: begin
                w_res = w_shr[WIDTH:1];
                c_o   = w_shr[0];
            end
            OP_SRA: begin
                w_res = w_sra[WIDTH:1];
                c_o   = w_sra[0];
            end
            OP_MUL: w_res = '0;
            default: err_o = (op_i >= OP_RSVD_FIRST);
        endcase
    end

    assign result_o = w_res;
    assign z_o      = (w_res == '0);
    assign n_o      = w_res[WIDTH-1];

endmodule

`default_nettype wire

// File: rtl/seq_alu.sv
// ============================================================================
// Module   : seq_alu
// Purpose  : Handshaked ALU: single-cycle ops plus a WIDTH-cycle shift-add MUL.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] result,
    output logic             z,
    output logic             n,
    output logic             c,
    output logic             v,
    output logic             err,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sticky_v,
    input  logic             clr_sticky
);

    localparam int CW = $clog2(WIDTH);

    state_e             state_q, state_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d, err_q, err_d;
    logic               out_valid_q, out_valid_d;
    logic               sticky_q, sticky_d;

    logic [WIDTH-1:0]   w_core_result;
    logic               w_core_z, w_core_n, w_core_c, w_core_v, w_core_err;
    logic               w_accept, w_is_mul, w_mul_done, w_mul_v, w_load_v;
    logic [2*WIDTH-1:0] w_acc_step;

    alu_core_comb #(
        .WIDTH (WIDTH)
    ) u_core (
        .a_i      (a),
        .b_i      (b),
        .op_i     (op),
        .result_o (w_core_result),
        .z_o      (w_core_z),
        .n_o      (w_core_n),
        .c_o      (w_core_c),
        .v_o      (w_core_v),
        .err_o    (w_core_err)
    );

    assign in_ready   = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_is_mul   = (op == OP_MUL);
    assign w_acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign w_mul_done = (state_q == ST_BUSY) && (cnt_q == CW'(WIDTH - 1));
    assign w_mul_v    = |w_acc_step[2*WIDTH-1:WIDTH];
    assign w_load_v   = (w_accept && !w_is_mul && w_core_v) || (w_mul_done && w_mul_v);

    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        z_d         = z_q;
        n_d         = n_q;
        c_d         = c_q;
        v_d         = v_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        sticky_d    = sticky_q;

        case (state_q)
            ST_IDLE: begin
                if (w_accept && w_is_mul) begin
                    state_d  = ST_BUSY;
                    mcand_d  = {{WIDTH{1'b0}}, a};
                    mplier_d = b;
                    acc_d    = '0;
                    cnt_d    = '0;
                end
            end
            ST_BUSY: begin
                acc_d    = w_acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (w_mul_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A pop and a new single-cycle load on the same edge keep out_valid high.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (w_accept && !w_is_mul) begin
            result_d    = w_core_result;
            z_d         = w_core_z;
            n_d         = w_core_n;
            c_d         = w_core_c;
            v_d         = w_core_v;
            err_d       = w_core_err;
            out_valid_d = 1'b1;
        end else if (w_mul_done) begin
            result_d    = w_acc_step[WIDTH-1:0];
            z_d         = (w_acc_step[WIDTH-1:0] == '0);
            n_d         = w_acc_step[WIDTH-1];
            c_d         = 1'b0;
            v_d         = w_mul_v;
            err_d       = 1'b0;
            out_valid_d = 1'b1;
        end

        if (w_load_v) begin
            sticky_d = 1'b1;
        end else if (clr_sticky) begin
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            z_q         <= 1'b1;
            n_q         <= 1'b0;
            c_q         <= 1'b0;
            v_q         <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            z_q         <= z_d;
            n_q         <= n_d;
            c_q         <= c_d;
            v_q         <= v_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            sticky_q    <= sticky_d;
        end
    end

    assign result    = result_q;
    assign z         = z_q;
    assign n         = n_q;
    assign c         = c_q;
    assign v         = v_q;
    assign err       = err_q;
    assign out_valid = out_valid_q;
    assign sticky_v  = sticky_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_alu.sv
// ============================================================================
// Module   : tb_seq_alu
// Purpose  : Directed and randomized self-checking bench for seq_alu (WIDTH=8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_alu;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [3:0]   op = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] result;
    logic         z, n, c, v, err;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic         sticky_v;
    logic         clr_sticky = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [W-1:0] r;
        logic z, n, c, v, err;
    } exp_t;

    seq_alu #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a          (a),
        .b          (b),
        .op         (op),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .result     (result),
        .z          (z),
        .n          (n),
        .c          (c),
        .v          (v),
        .err        (err),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sticky_v   (sticky_v),
        .clr_sticky (clr_sticky)
    );

    always #5 clk = ~clk;

    // Reference: integer arithmetic on unsigned/signed interpretations of the operands.
    function automatic exp_t model(input int opc, input longint ua, input longint ub);
        exp_t   e;
        longint m, half, sa, sb, s;
        int     k;
        m    = longint'(1) << W;
        half = m / 2;
        sa   = (ua >= half) ? ua - m : ua;
        sb   = (ub >= half) ? ub - m : ub;
        k    = int'(ub % W);
        e    = '0;
        s    = 0;
        case (opc)
            0: s = ua & ub;
            1: s = ua | ub;
            2: s = ua ^ ub;
            3: s = (m - 1) - ub;
            4: begin s = ua + ub; e.c = (s >= m); e.v = (sa + sb >= half) || (sa + sb < -half); end
            5: begin s = ua + (m - 1 - ub) + 1; e.c = (s >= m); e.v = (sa - sb >= half) || (sa - sb < -half); end
            6: begin s = ub + 1; e.c = (s >= m); e.v = (sb + 1 >= half); end
            7: begin s = m - ua; e.c = (ua == 0); e.v = (-sa >= half); end
            8: begin s = ua << k; e.c = (k > 0) && (((ua >> (W - k)) & 1) != 0); end
            9: begin s = ua >> k; e.c = (k > 0) && (((ua >> (k - 1)) & 1) != 0); end
            10: begin s = sa >>> k; e.c = (k > 0) && (((sa >>> (k - 1)) & 1) != 0); end
            11: begin s = ua * ub; e.v = ((s >> W) != 0); end
            default: begin s = 0; e.err = 1'b1; end
        endcase
        e.r = W'(s & (m - 1));
        e.z = (e.r == '0);
        e.n = e.r[W-1];
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives an op at a negedge, waits (bounded) for acceptance, returns at the next negedge.
    task automatic send(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        int waited;
        op = o; a = x; b = y; in_valid = 1'b1;
        waited = 0;
        while (!in_ready && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        chk("send_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid   = 1'b0;
        clr_sticky = 1'b0;
    endtask

    task automatic wait_out(output int cyc);
        cyc = 1;
        while (!out_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t         e;
        int           cyc, lo, rises;
        logic         st;
        logic [3:0]   o;
        logic [W-1:0] x, y;
        logic         clr;

        // Reset values
        repeat (2) @(negedge clk);
        chk("reset_outs", {result, z, n, c, v, err, out_valid, sticky_v},
            {8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", {63'd0, in_ready}, 64'd1);

        // ADD overflow into sign bit
        send(4'd4, 8'h7F, 8'h01);
        chk("add_vec", {out_valid, result, z, n, c, v, err}, {1'b1, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
        chk("add_sticky", {63'd0, sticky_v}, 64'd1);

        send(4'd5, 8'h05, 8'h05);
        chk("sub_eq", {result, z, c, v}, {8'h00, 1'b1, 1'b1, 1'b0});
        send(4'd10, 8'h90, 8'h02);
        chk("sra", {result, c, v}, {8'hE4, 1'b0, 1'b0});

        // MUL latency and busy window
        send(4'd11, 8'h10, 8'h11);
        cyc = 1;
        lo  = 0;
        while (!out_valid && cyc < 40) begin
            if (!in_ready) lo++;
            @(negedge clk);
            cyc++;
        end
        chk("mul_busy_cycles", 64'(lo), 64'd8);
        chk("mul_latency", 64'(cyc), 64'd9);
        chk("mul_vec", {result, c, v, err}, {8'h10, 1'b0, 1'b1, 1'b0});

        // Backpressure: first result held, second op waits, pop and accept share an edge
        @(negedge clk);
        out_ready = 1'b0;
        send(4'd0, 8'hF0, 8'h3C);
        op = 4'd2; a = 8'hAA; b = 8'h0F; in_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("bp_hold", {in_ready, out_valid, result}, {1'b0, 1'b1, 8'h30});
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_pop_load", {out_valid, result}, {1'b1, 8'hA5});
        @(negedge clk);
        chk("bp_drain", {63'd0, out_valid}, 64'd0);

        // Reset on the fourth BUSY cycle aborts the multiply
        send(4'd11, 8'hFF, 8'hFF);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_outs", {out_valid, sticky_v}, {1'b0, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        rises = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) rises++;
        end
        chk("abort_no_result", 64'(rises), 64'd0);
        chk("abort_in_ready", {63'd0, in_ready}, 64'd1);
        send(4'd4, 8'h01, 8'h01);
        chk("abort_add", {out_valid, result}, {1'b1, 8'h02});

        // Reserved opcode
        send(4'hD, 8'h5A, 8'h33);
        chk("reserved", {result, err, z, n, c, v}, {8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});

        // Clear and set on the same edge: set wins; clear alone drops it
        clr_sticky = 1'b1;
        send(4'd4, 8'h7F, 8'h01);
        chk("sticky_set_wins", {63'd0, sticky_v}, 64'd1);
        clr_sticky = 1'b1;
        @(negedge clk);
        clr_sticky = 1'b0;
        chk("sticky_clear", {63'd0, sticky_v}, 64'd0);

        // Randomized ops against the reference model
        st = 1'b0;
        for (int i = 0; i < 300; i++) begin
            o   = 4'($urandom_range(0, 15));
            x   = W'($urandom);
            y   = W'($urandom);
            clr = ($urandom_range(0, 7) == 0);
            e   = model(int'(o), longint'(x), longint'(y));
            clr_sticky = clr;
            send(o, x, y);
            if (clr) st = 1'b0;
            wait_out(cyc);
            chk("rnd_latency", 64'(cyc), (o == 4'd11) ? 64'(W + 1) : 64'd1);
            chk("rnd_vec", {out_valid, result, z, n, c, v, err}, {1'b1, e});
            st = st | e.v;
            chk("rnd_sticky", {63'd0, sticky_v}, {63'd0, st});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand and result width; legal values are 2 to 32.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have ports a, b, input, WIDTH bits each: operands.
REQ-005 SHALL have port op, input, 4 bits: opcode, encoded per REQ-012.
REQ-006 SHALL have ports in_valid (input, 1 bit) and in_ready (output, 1 bit): the operand handshake.
REQ-007 SHALL have port result, output, WIDTH bits: the registered result.
REQ-008 SHALL have ports z, n, c, v, output, 1 bit each: zero, negative (result MSB), carry, overflow flags, registered with result.
REQ-009 SHALL have port err, output, 1 bit: set when a reserved opcode was executed.
REQ-010 SHALL have ports out_valid (output, 1 bit) and out_ready (input, 1 bit): the result handshake.
REQ-011 SHALL have ports sticky_v (output, 1 bit) and clr_sticky (input, 1 bit): accumulated overflow and its clear.

Function
REQ-012 Opcodes SHALL be: 0 AND; 1 OR; 2 XOR; 3 NOT b; 4 ADD a+b; 5 SUB a-b; 6 INC b+1; 7 NEG -a; 8 SHL a; 9 SHR a (logical); 10 SRA a; 11 MUL a*b, low WIDTH bits; 12-15 reserved.
REQ-013 An operation SHALL be accepted on a rising edge where in_valid and in_ready are both 1; in_ready = (state==IDLE) && (!out_valid || out_ready).
REQ-014 The FSM SHALL have states IDLE and BUSY. IDLE moves to BUSY on acceptance of MUL. BUSY returns to IDLE after exactly WIDTH cycles.
REQ-015 Non-MUL ops SHALL have latency 1: result, flags and out_valid=1 appear in the cycle after acceptance.
REQ-016 MUL SHALL be computed by an iterative shift-add over WIDTH cycles; out_valid rises WIDTH+1 cycles after acceptance; in_ready stays 0 while BUSY.
REQ-017 result, flags and out_valid SHALL hold stable while out_valid=1 and out_ready=0.
REQ-018 out_valid SHALL fall on the edge where out_valid && out_ready, unless a non-MUL op is accepted on the same edge; in that case the new result loads and out_valid stays 1.
REQ-019 ADD, SUB and INC carry SHALL be the adder carry-out; SUB is computed as a+~b+1, so c=1 means no borrow. ADD/SUB v = carry into MSB XOR carry out.
REQ-020 NEG SHALL set v=1 only for a = 100..0 and c=1 only for a=0. INC SHALL set v=1 only for b = 011..1.
REQ-021 Shift amount SHALL be b[$clog2(WIDTH)-1:0]. c = last bit shifted out, or 0 when the amount is 0. v=0.
REQ-022 MUL SHALL set v=1 when the upper WIDTH bits of the unsigned 2*WIDTH product are non-zero; c=0.
REQ-023 Logic ops SHALL drive c=0 and v=0.
REQ-024 Reserved ops SHALL give result=0, z=1, n=c=v=0, err=1. err SHALL be 0 for all other ops.
REQ-025 sticky_v SHALL set when a result with v=1 loads. clr_sticky clears it. If set and clear occur on the same edge, set wins.

Reset
REQ-026 While rst_n=0, the following SHALL hold: state=IDLE; result=0; z=1; n=c=v=err=0; out_valid=0; sticky_v=0; multiplier registers cleared. in_ready is 1 from the first edge after release.
REQ-027 Reset asserted during BUSY SHALL abort the MUL with no result delivered.

Structure
REQ-028 Package seq_alu_pkg SHALL hold the opcode enum (4-bit), the state enum (IDLE/BUSY) and the reserved-opcode boundary constant.
REQ-029 Single-cycle ops SHALL be in one combinational sub-module alu_core_comb, parametrised by WIDTH. The MUL datapath, FSM and output registers stay in seq_alu.

Verification (WIDTH=8)
REQ-030 ADD a=0x7F b=0x01 -> next cycle result=0x80, n=1, v=1, c=0, z=0; sticky_v=1.
REQ-031 SUB a=0x05 b=0x05 -> result=0x00, z=1, c=1, v=0. SRA a=0x90 b=0x02 -> result=0xE4, c=0.
REQ-032 MUL a=0x10 b=0x11 -> in_ready=0 for 8 cycles; out_valid rises 9 cycles after accept; result=0x10, v=1.
REQ-033 out_ready=0 with ops streaming -> first result held stable, in_ready=0. out_ready=1 for one cycle -> first result popped and next op accepted on the same edge.
REQ-034 rst_n low on the 4th BUSY cycle of a MUL -> out_valid=0 and sticky_v=0; after release in_ready=1 and a fresh ADD 0x01+0x01 gives 0x02.
REQ-035 op=0xD -> result=0x00, err=1, z=1. clr_sticky and a v=1 result on the same edge -> sticky_v=1.
